// File: rtl/adder_scan_display.sv
// Adds two switch operands with carry-in, converts the sum to BCD with a
// sequential double-dabble engine and multiplexes it onto a 4-digit display.
module adder_scan_display #(
  parameter int WIDTH       = 8,
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic [6:0]       seg,
  output logic [3:0]       an,
  output logic             busy
);

  localparam int SW = WIDTH + 1;
  localparam int CW = $clog2(SW + 1);
  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] LOAD    = 2'd2;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             ci_q;
  logic [SW-1:0]    sum;

  logic [1:0]       state;
  logic [SW-1:0]    last_sum;
  logic [SW-1:0]    bin;
  logic [15:0]      bcd;
  logic [15:0]      bcd_adj;
  logic [CW-1:0]    bit_cnt;
  logic [3:0]       d0;
  logic [3:0]       d1;
  logic [3:0]       d2;
  logic [3:0]       d3;

  logic [RW-1:0]    refresh_cnt;
  logic [1:0]       idx;
  logic [3:0]       cur_digit;
  logic [3:0]       lz;
  logic             blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      ci_q <= 1'b0;
    end else begin
      a_q  <= A;
      b_q  <= B;
      ci_q <= CI;
    end
  end

  assign sum = {1'b0, a_q} + {1'b0, b_q} + SW'(ci_q);

  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_sum <= '0;
      bin      <= '0;
      bcd      <= '0;
      bit_cnt  <= '0;
      d0       <= '0;
      d1       <= '0;
      d2       <= '0;
      d3       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sum != last_sum) begin
            bin      <= sum;
            last_sum <= sum;
            bcd      <= '0;
            bit_cnt  <= CW'(SW);
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          bcd     <= {bcd_adj[14:0], bin[SW-1]};
          bin     <= {bin[SW-2:0], 1'b0};
          bit_cnt <= bit_cnt - CW'(1);
          if (bit_cnt == CW'(1)) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          d0    <= bcd[3:0];
          d1    <= bcd[7:4];
          d2    <= bcd[11:8];
          d3    <= bcd[15:12];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      idx         <= '0;
    end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      idx         <= idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  assign an = ~(4'b0001 << idx);

  always_comb begin
    cur_digit = d0;
    case (idx)
      2'd0: cur_digit = d0;
      2'd1: cur_digit = d1;
      2'd2: cur_digit = d2;
      2'd3: cur_digit = d3;
      default: cur_digit = d0;
    endcase
  end

  // lz[k] is set when digit k and everything above it are zero; digit 0 never blanks.
  always_comb begin
    lz[3] = (d3 == 4'd0);
    lz[2] = lz[3] && (d2 == 4'd0);
    lz[1] = lz[2] && (d1 == 4'd0);
    lz[0] = 1'b0;
    blank = BLANK_LZ && lz[idx];
  end

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0: seg_of = 7'b1000000;
      4'd1: seg_of = 7'b1111001;
      4'd2: seg_of = 7'b0100100;
      4'd3: seg_of = 7'b0110000;
      4'd4: seg_of = 7'b0011001;
      4'd5: seg_of = 7'b0010010;
      4'd6: seg_of = 7'b0000010;
      4'd7: seg_of = 7'b1111000;
      4'd8: seg_of = 7'b0000000;
      4'd9: seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  assign seg = blank ? 7'b1111111 : seg_of(cur_digit);

endmodule
